// File: rtl/acia_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// acia_rx_fifo_if
// Bundle of the receive-FIFO handshake signals between the ACIA bus/receiver
// logic (master) and the FIFO itself (slave). DEPTH must match the FIFO
// instance so that the count field has the right width.
// ---------------------------------------------------------------------------
interface acia_rx_fifo_if #(
    parameter int DEPTH = 16
) ();
    localparam int AW = $clog2(DEPTH);

    // Producer / consumer controls
    logic          clr;
    logic [7:0]    wr_dat;
    logic          wr_err;
    logic          wr_stb;
    logic          rd_stb;
    logic          ovr_clr;

    // FIFO status and head entry
    logic [7:0]    rd_dat;
    logic          rd_err;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          ovr;

    modport master (
        output clr, wr_dat, wr_err, wr_stb, rd_stb, ovr_clr,
        input  rd_dat, rd_err, empty, full, count, ovr
    );

    modport slave (
        input  clr, wr_dat, wr_err, wr_stb, rd_stb, ovr_clr,
        output rd_dat, rd_err, empty, full, count, ovr
    );
endinterface

// File: rtl/acia_rx_fifo.sv
// ---------------------------------------------------------------------------
// acia_rx_fifo
// Receive-side byte buffer between the ACIA serial receiver and the CPU
// register logic. Holds DEPTH entries of {err, data}; pointers are AW+1 bits
// so that full and empty are distinguishable without a separate counter.
//
// Optional build macro: ACIA_RX_FIFO_FWFT_EN
//   undefined : rd_dat/rd_err load the head entry on the edge of a valid pop
//   defined   : first-word fall-through; the head entry is shown continuously
//               and empty is delayed one cycle to line up with the data
//
// DEPTH must be a power of two and at least 2.
// ---------------------------------------------------------------------------
module acia_rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    acia_rx_fifo_if.slave  bus
);

    localparam logic [AW:0] PTR_ZERO = (AW+1)'(0);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Storage and state
    logic [8:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [7:0]  rd_dat_r;
    logic        rd_err_r;
    logic        ovr_r;

    // Derived status and next-state terms
    logic [AW:0] count_s;
    logic        empty_int_s;
    logic        full_s;
    logic        pop_ok_s;
    logic        push_ok_s;
    logic        ovf_s;
    logic [AW:0] wr_ptr_nxt_s;
    logic [AW:0] rd_ptr_nxt_s;

`ifdef ACIA_RX_FIFO_FWFT_EN
    // Output register holds a valid head entry
    logic        show_vld_r;
    logic [AW:0] avail_s;
    logic        head_rdy_s;
    logic [8:0]  head_s;
`else
    logic [8:0]  pop_data_s;
`endif

    // Occupancy derived purely from the registered pointers
    always_comb begin
        count_s     = wr_ptr_r - rd_ptr_r;
        empty_int_s = (count_s == PTR_ZERO);
        full_s      = (count_s == FULL_CNT);
    end

    // Strobe qualification and next pointer values
    always_comb begin
        pop_ok_s     = 1'b0;
        push_ok_s    = 1'b0;
        ovf_s        = 1'b0;
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
`ifdef ACIA_RX_FIFO_FWFT_EN
        // The CPU can only pop what it has been shown
        pop_ok_s     = bus.rd_stb & show_vld_r;
`else
        pop_ok_s     = bus.rd_stb & ~empty_int_s;
`endif
        // A pop frees a slot in the same cycle, so full plus pop still accepts
        push_ok_s    = bus.wr_stb & (~full_s | pop_ok_s);
        ovf_s        = bus.wr_stb & full_s & ~pop_ok_s;
        if (push_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
    end

`ifdef ACIA_RX_FIFO_FWFT_EN
    // Head after this edge, only if it was already written before this edge
    always_comb begin
        avail_s    = wr_ptr_r - rd_ptr_nxt_s;
        head_rdy_s = (avail_s != PTR_ZERO);
        head_s     = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
`else
    // Current head entry, loaded into the output register on a valid pop
    always_comb begin
        pop_data_s = mem_r[rd_ptr_r[AW-1:0]];
    end
`endif

    // Array write; validity is tracked by the pointers so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok_s && !bus.clr) begin
            mem_r[wr_ptr_r[AW-1:0]] <= {bus.wr_err, bus.wr_dat};
        end
    end

    // Pointers and sticky overrun flag; clr flushes and overrides strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            ovr_r    <= 1'b0;
        end else if (bus.clr) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            ovr_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            // A drop in the same cycle as a clear request keeps the flag set
            if (ovf_s) begin
                ovr_r <= 1'b1;
            end else if (bus.ovr_clr) begin
                ovr_r <= 1'b0;
            end else begin
                ovr_r <= ovr_r;
            end
        end
    end

`ifdef ACIA_RX_FIFO_FWFT_EN
    // Fall-through output register: refresh from the array whenever a head exists
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_dat_r   <= 8'h00;
            rd_err_r   <= 1'b0;
            show_vld_r <= 1'b0;
        end else if (bus.clr) begin
            rd_dat_r   <= 8'h00;
            rd_err_r   <= 1'b0;
            show_vld_r <= 1'b0;
        end else if (head_rdy_s) begin
            rd_err_r   <= head_s[8];
            rd_dat_r   <= head_s[7:0];
            show_vld_r <= 1'b1;
        end else begin
            // Nothing to show: keep the last byte, report empty
            rd_dat_r   <= rd_dat_r;
            rd_err_r   <= rd_err_r;
            show_vld_r <= 1'b0;
        end
    end
`else
    // Registered pop-load output: head entry captured on each valid pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_dat_r <= 8'h00;
            rd_err_r <= 1'b0;
        end else if (bus.clr) begin
            rd_dat_r <= 8'h00;
            rd_err_r <= 1'b0;
        end else if (pop_ok_s) begin
            rd_err_r <= pop_data_s[8];
            rd_dat_r <= pop_data_s[7:0];
        end else begin
            rd_dat_r <= rd_dat_r;
            rd_err_r <= rd_err_r;
        end
    end
`endif

    // Status outputs come from registers or register-only logic
    assign bus.rd_dat = rd_dat_r;
    assign bus.rd_err = rd_err_r;
    assign bus.full   = full_s;
    assign bus.count  = count_s;
    assign bus.ovr    = ovr_r;
`ifdef ACIA_RX_FIFO_FWFT_EN
    assign bus.empty  = ~show_vld_r;
`else
    assign bus.empty  = empty_int_s;
`endif

endmodule

// File: tb/tb_acia_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_acia_rx_fifo
// Directed bench for acia_rx_fifo (DEPTH = 16). Honours ACIA_RX_FIFO_FWFT_EN
// so the same vectors cover both read-timing variants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_acia_rx_fifo;

`ifdef ACIA_RX_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   chk_cnt;
    int   pass_cnt;
    logic [8:0] q [$];

    acia_rx_fifo_if #(.DEPTH(16)) bus ();

    acia_rx_fifo #(.DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        bus.wr_dat = d;
        bus.wr_err = e;
        bus.wr_stb = 1'b1;
        step();
        bus.wr_stb = 1'b0;
    endtask

    // Read one entry and compare it with the expected byte/flag
    task automatic pop_check(input string tag, input logic [7:0] d, input logic e);
        if (FWFT) begin
            for (int i = 0; i < 3 && bus.empty; i++) step();
            check({tag, "_vis"}, 32'(bus.empty), 32'd0);
            check({tag, "_dat"}, 32'(bus.rd_dat), 32'(d));
            check({tag, "_err"}, 32'(bus.rd_err), 32'(e));
            bus.rd_stb = 1'b1;
            step();
            bus.rd_stb = 1'b0;
        end else begin
            bus.rd_stb = 1'b1;
            step();
            bus.rd_stb = 1'b0;
            check({tag, "_dat"}, 32'(bus.rd_dat), 32'(d));
            check({tag, "_err"}, 32'(bus.rd_err), 32'(e));
        end
    endtask

    initial begin
        logic [7:0] nxt;
        int         tgt;
        chk_cnt     = 0;
        pass_cnt    = 0;
        rst         = 1'b0;
        bus.clr     = 1'b0;
        bus.wr_dat  = 8'h00;
        bus.wr_err  = 1'b0;
        bus.wr_stb  = 1'b0;
        bus.rd_stb  = 1'b0;
        bus.ovr_clr = 1'b0;

        // Reset then idle
        repeat (3) step();
        check("rst_empty", 32'(bus.empty), 32'd1);
        rst = 1'b1;
        step();
        check("idle_empty", 32'(bus.empty), 32'd1);
        check("idle_full",  32'(bus.full),  32'd0);
        check("idle_count", 32'(bus.count), 32'd0);
        check("idle_ovr",   32'(bus.ovr),   32'd0);
        check("idle_dat",   32'(bus.rd_dat), 32'h00);
        check("idle_err",   32'(bus.rd_err), 32'd0);
        bus.rd_stb = 1'b1;
        step();
        bus.rd_stb = 1'b0;
        check("rd_empty_count", 32'(bus.count), 32'd0);
        check("rd_empty_empty", 32'(bus.empty), 32'd1);
        check("rd_empty_dat",   32'(bus.rd_dat), 32'h00);

        // Ordered transfer, including one-cycle-later visibility in FWFT
        push(8'h41, 1'b0);
        check("push1_count", 32'(bus.count), 32'd1);
        check("push1_empty", 32'(bus.empty), FWFT ? 32'd1 : 32'd0);
        push(8'h42, 1'b0);
        check("push2_empty", 32'(bus.empty), 32'd0);
        push(8'h43, 1'b1);
        check("push3_count", 32'(bus.count), 32'd3);
        pop_check("ord0", 8'h41, 1'b0);
        check("ord0_count", 32'(bus.count), 32'd2);
        pop_check("ord1", 8'h42, 1'b0);
        check("ord1_count", 32'(bus.count), 32'd1);
        pop_check("ord2", 8'h43, 1'b1);
        check("ord2_count", 32'(bus.count), 32'd0);
        check("ord2_empty", 32'(bus.empty), 32'd1);
        bus.rd_stb = 1'b1;
        step();
        bus.rd_stb = 1'b0;
        check("hold_dat", 32'(bus.rd_dat), 32'h43);
        check("hold_err", 32'(bus.rd_err), 32'd1);

        // Fill, overflow, drain, clear overrun
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
        check("fill_full",  32'(bus.full),  32'd1);
        check("fill_count", 32'(bus.count), 32'd16);
        check("fill_ovr",   32'(bus.ovr),   32'd0);
        push(8'hFF, 1'b1);
        check("ovf_ovr",   32'(bus.ovr),   32'd1);
        check("ovf_count", 32'(bus.count), 32'd16);
        for (int i = 0; i < 16; i++) pop_check($sformatf("drain%0d", i), 8'(i), 1'b0);
        check("drain_empty", 32'(bus.empty), 32'd1);
        check("drain_ovr",   32'(bus.ovr),   32'd1);
        bus.ovr_clr = 1'b1;
        step();
        bus.ovr_clr = 1'b0;
        check("ovrclr_ovr", 32'(bus.ovr), 32'd0);

        // Full: overflow beats ovr_clr, then simultaneous push and pop
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b0);
        bus.wr_dat  = 8'hEE;
        bus.wr_stb  = 1'b1;
        bus.ovr_clr = 1'b1;
        step();
        bus.wr_stb  = 1'b0;
        bus.ovr_clr = 1'b0;
        check("setwins_ovr",   32'(bus.ovr),   32'd1);
        check("setwins_count", 32'(bus.count), 32'd16);
        bus.ovr_clr = 1'b1;
        step();
        bus.ovr_clr = 1'b0;
        check("ovrclr2_ovr", 32'(bus.ovr), 32'd0);
        if (FWFT) check("fullpp_head", 32'(bus.rd_dat), 32'h20);
        bus.wr_dat = 8'h55;
        bus.wr_err = 1'b0;
        bus.wr_stb = 1'b1;
        bus.rd_stb = 1'b1;
        step();
        bus.wr_stb = 1'b0;
        bus.rd_stb = 1'b0;
        if (!FWFT) check("fullpp_dat", 32'(bus.rd_dat), 32'h20);
        check("fullpp_count", 32'(bus.count), 32'd16);
        check("fullpp_ovr",   32'(bus.ovr),   32'd0);
        for (int i = 1; i < 16; i++) pop_check($sformatf("pp%0d", i), 8'h20 + 8'(i), 1'b0);
        pop_check("pp_last", 8'h55, 1'b0);
        check("pp_empty", 32'(bus.empty), 32'd1);

        // Empty: simultaneous push and pop keeps the push only
        bus.wr_dat = 8'h66;
        bus.wr_err = 1'b1;
        bus.wr_stb = 1'b1;
        bus.rd_stb = 1'b1;
        step();
        bus.wr_stb = 1'b0;
        bus.rd_stb = 1'b0;
        check("emptypp_count", 32'(bus.count), 32'd1);
        check("emptypp_dat",   32'(bus.rd_dat), 32'h55);
        check("emptypp_empty", 32'(bus.empty), FWFT ? 32'd1 : 32'd0);
        pop_check("emptypp_pop", 8'h66, 1'b1);

        // Wrap-around at varying fill levels against a queue model
        nxt = 8'h80;
        for (int i = 0; i < 40; i++) begin
            push(nxt, nxt[0]);
            q.push_back({nxt[0], nxt});
            nxt = nxt + 8'h01;
            check("wrap_count", 32'(bus.count), 32'(q.size()));
            tgt = int'($urandom_range(0, 15));
            while (q.size() > tgt) begin
                logic [8:0] ent;
                ent = q.pop_front();
                pop_check("wrap", ent[7:0], ent[8]);
            end
        end
        while (q.size() > 0) begin
            logic [8:0] ent;
            ent = q.pop_front();
            pop_check("wrap_drain", ent[7:0], ent[8]);
        end
        check("wrap_empty", 32'(bus.empty), 32'd1);

        // Flush with overrun pending and strobes active
        for (int i = 0; i < 16; i++) push(8'h90 + 8'(i), 1'b0);
        push(8'hAA, 1'b0);
        check("preflush_ovr", 32'(bus.ovr), 32'd1);
        bus.clr    = 1'b1;
        bus.wr_dat = 8'h33;
        bus.wr_stb = 1'b1;
        bus.rd_stb = 1'b1;
        step();
        bus.clr    = 1'b0;
        bus.wr_stb = 1'b0;
        bus.rd_stb = 1'b0;
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_empty", 32'(bus.empty), 32'd1);
        check("flush_ovr",   32'(bus.ovr),   32'd0);
        check("flush_dat",   32'(bus.rd_dat), 32'h00);
        push(8'h7E, 1'b0);
        pop_check("postflush", 8'h7E, 1'b0);

        // Asynchronous reset in the middle of traffic
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_empty", 32'(bus.empty), 32'd1);
        rst = 1'b1;
        step();
        push(8'h11, 1'b1);
        pop_check("postrst", 8'h11, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/acia_rx_fifo.md
Name: acia_rx_fifo

Overview:
- Receive-side byte buffer between the ACIA serial receiver and the ACIA bus register logic.
- Captures each received byte and its error flag on the receiver's strobe and holds up to DEPTH entries.
- Presents the oldest entry to the CPU read path, with status flags for empty, full, fill count and sticky overrun.
- Removes the single-byte overrun limit at 115200 baud when the 6502 services interrupts late.

Parameters:
DEPTH, 16, number of entries; must be a power of 2 and at least 2
AW, $clog2(DEPTH), pointer address width (derived; do not override)

Ports:
clk      input   1     system clock
rst      input   1     asynchronous reset, active-low
clr      input   1     synchronous flush; driven high while the ACIA master reset (divide select = 11) is active
wr_dat   input   8     received byte from serial receiver
wr_err   input   1     receiver framing/error flag for wr_dat
wr_stb   input   1     one-cycle push strobe (receiver rx_stb)
rd_stb   input   1     one-cycle pop strobe (CPU read of RX data register)
rd_dat   output  8     head data byte
rd_err   output  1     error flag stored with rd_dat
empty    output  1     no entries held
full     output  1     DEPTH entries held
count    output  AW+1  number of entries held, 0..DEPTH
ovr      output  1     sticky overrun: a push was dropped
ovr_clr  input   1     clears ovr

Behaviour:
- Storage: DEPTH x 9-bit array holding {err, data}. Write and read pointers are each AW+1 bits and wrap naturally modulo 2*DEPTH.
- count = wr_ptr - rd_ptr. empty = (count == 0). full = (count == DEPTH). All three are registered or derived from registered pointers, with no combinational path from strobes.
- Reset (rst low, async) values:
  - pointers = 0, rd_dat = 8'h00, rd_err = 0, empty = 1, full = 0, count = 0, ovr = 0.
  - Reset mid-transfer discards all contents immediately.
- clr (sync, highest priority after rst): pointers to 0, ovr to 0, rd_dat/rd_err to 0. Any same-cycle push and pop are ignored.
- Push accepted when wr_stb & (~full | pop_ok). The entry is written at wr_ptr and wr_ptr increments. Flags update at that same edge.
- Pop is valid when rd_stb & ~empty (pop_ok). rd_ptr increments. rd_stb while empty is ignored: pointers unchanged, rd_dat and rd_err hold their values.
- Full plus simultaneous push and pop: both occur, count stays DEPTH, ovr is not set.
- Empty plus simultaneous push and pop: the pop is ignored and the push occurs, so count becomes 1.
- Full plus push with no pop: byte dropped, contents unchanged, ovr <= 1.
- ovr_clr clears ovr. If an overflow occurs in the same cycle, set wins.
- Read timing (default, non-FWFT): on a valid pop at edge N, rd_dat/rd_err load the head entry at edge N. The values are stable from then until the next valid pop. This matches the ACIA's registered dout path, which samples rd_dat one cycle after the read strobe.
- Push-to-flag latency: a push at edge N gives empty = 0 and count + 1 after edge N.
- No other state machine: the block is pointer/counter based only.

Optional Feature:
- Macro: ACIA_RX_FIFO_FWFT_EN.
- Defined: first-word fall-through.
  - rd_dat/rd_err continuously show the head entry, registered from the array, whenever ~empty.
  - A push into an empty FIFO at edge N makes the data visible after edge N+1. empty deasserts together with the data valid, i.e. empty is delayed one cycle to match.
  - A valid pop at edge N presents the next entry after edge N. When the FIFO becomes empty, rd_dat/rd_err hold their last value.
- Undefined: registered pop-load behaviour as described in Behaviour.

Test Plan:
- Reset then idle: hold rst low, release; check empty=1, full=0, count=0, ovr=0, rd_dat=8'h00. Then rd_stb with empty → no change.
- Ordered transfer: push 8'h41, 8'h42, 8'h43 (wr_err=0, 0, 1), then three pops → rd_dat 41/42/43 with rd_err 0/0/1, count 3→0, empty reasserts after the third pop.
- Fill and overflow (DEPTH=16): push 16 bytes 8'h00..8'h0F → full=1, count=16. Push 8'hFF → ovr=1, and popping all 16 returns 00..0F (FF absent). Then ovr_clr → ovr=0.
- Simultaneous push/pop: with full, push 8'h55 and pop in the same cycle → count stays 16, ovr=0, 8'h55 is the last byte popped. With empty, push and pop together → count=1.
- Wrap-around: 40 push/pop pairs of incrementing bytes at random fill levels 0..15 → data order preserved across pointer wrap, count is never out of range.
- Flush: fill 5 entries, assert clr with wr_stb high in the same cycle → count=0, empty=1, ovr=0. The next push of 8'h7E pops as 8'h7E. Repeat all tests with ACIA_RX_FIFO_FWFT_EN defined, checking the one-cycle-later data visibility.
